// File: rtl/map_pkg.sv
// Shared map constants and terrain rule.
// Used by the map write-port arbiter.
package map_pkg;

  localparam int MAP_ADDR_W = 15;
  localparam int BLOCK_ID_W = 5;

  localparam logic [BLOCK_ID_W-1:0] AIR   = BLOCK_ID_W'(0);
  localparam logic [BLOCK_ID_W-1:0] STONE = BLOCK_ID_W'(1);
  localparam logic [BLOCK_ID_W-1:0] GRASS = BLOCK_ID_W'(2);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } arb_state_e;

  // Initial block id for a cell, from its height layer h.
  function automatic logic [BLOCK_ID_W-1:0] terrain_id(
    input logic [4:0] h,
    input int         ground_h,
    input int         ground_id,
    input int         grass_id
  );
    if (int'(h) < ground_h) begin
      return BLOCK_ID_W'(ground_id);
    end
    if (int'(h) == ground_h) begin
      return BLOCK_ID_W'(grass_id);
    end
    return AIR;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant
);

  logic rr_q;
  logic rr_d;

  // Tie goes to the pointer; a lone requester always wins.
  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end
  end

  // After a grant, favour the requester that did not win.
  always_comb begin
    rr_d = rr_q;
    if (advance && (|grant)) begin
      rr_d = grant[0];
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/map_write_arb.sv
// Map block-RAM write-port owner: terrain sweep after
// reset, then blank-gated arbitration of block edits.
module map_write_arb
  import map_pkg::*;
#(
  parameter int ADDR_W     = MAP_ADDR_W,
  parameter int ID_W       = BLOCK_ID_W,
  parameter int GROUND_H   = 8,
  parameter int GROUND_ID  = int'(STONE),
  parameter int GRASS_ID   = int'(GRASS),
  parameter bit GATE_BLANK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ID_W-1:0]   req_data0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ID_W-1:0]   req_data1,
  output logic [1:0]        req_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ID_W-1:0]   write_data,
  output logic              write_en,
  output logic              init_done,
  output logic [15:0]       edit_count
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ID_W-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic [15:0]       ecnt_q, ecnt_d;

  logic       open_win;
  logic       idle;
  logic [1:0] eligible;
  logic [1:0] grant;

  // Edits are only eligible in IDLE and inside the window.
  always_comb begin
    open_win = ~GATE_BLANK | blank;
    idle     = (state_q == ST_IDLE);
    eligible = req_valid & {2{open_win & idle}};
  end

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .advance  (idle),
    .grant    (grant)
  );

  assign req_ready = grant;

  // Next-state: sweep in INIT, commit granted edit in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = done_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      ST_INIT: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = ID_W'(terrain_id(
                    cnt_q[ADDR_W-1 -: 5],
                    GROUND_H, GROUND_ID, GRASS_ID));
        cnt_d   = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        unique case (1'b1)
          grant[1]: begin
            we_d    = 1'b1;
            waddr_d = req_addr1;
            wdata_d = req_data1;
            ecnt_d  = ecnt_q + 16'd1;
          end
          grant[0]: begin
            we_d    = 1'b1;
            waddr_d = req_addr0;
            wdata_d = req_data0;
            ecnt_d  = ecnt_q + 16'd1;
          end
          default: begin
            we_d = 1'b0;
          end
        endcase
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State, sweep counter and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign write_en   = we_q;
  assign init_done  = done_q;
  assign edit_count = ecnt_q;

endmodule

// File: tb/tb_map_write_arb.sv
// Scoreboard bench for map_write_arb: reference model
// queues expected writes, monitor pops on write_en.
module tb_map_write_arb;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] a;
    logic [4:0]    d;
    logic [15:0]   c;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          blank = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [4:0]    req_data0 = '0;
  logic [4:0]    req_data1 = '0;
  logic [1:0]    req_ready;
  logic [AW-1:0] write_addr;
  logic [4:0]    write_data;
  logic          write_en;
  logic          init_done;
  logic [15:0]   edit_count;

  map_write_arb #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .blank      (blank),
    .req_valid  (req_valid),
    .req_addr0  (req_addr0),
    .req_data0  (req_data0),
    .req_addr1  (req_addr1),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en),
    .init_done  (init_done),
    .edit_count (edit_count)
  );

  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  bit          m_init = 1'b1;
  int          m_cnt = 0;
  bit          m_rr = 1'b0;
  logic [15:0] m_count = '0;

  bit          done_m = 1'b0;
  logic [15:0] cnt_m = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic logic [4:0] terrain(input int a);
    int h;
    h = a / (DEPTH / 32);
    if (h < 8) return 5'd1;
    if (h == 8) return 5'd2;
    return 5'd0;
  endfunction

  // Monitor: every write must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (write_en === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_write", {1'b1, write_addr}, 0);
        end else begin
          e = q.pop_front();
          chk("write", {write_addr, write_data,
                        edit_count, init_done},
                       {e.a, e.d, e.c, e.done});
          done_m = e.done;
          cnt_m  = e.c;
        end
      end else begin
        chk("idle_status", {init_done, edit_count},
                           {done_m, cnt_m});
      end
      if (rst) begin
        done_m = 1'b0;
        cnt_m  = '0;
      end
    end
  end

  // One clock of reference model; g is the model's grant.
  task automatic cycle(output logic [1:0] g);
    logic [1:0] el;
    exp_t e;
    g = 2'b00;
    @(negedge clk);
    if (rst) begin
      m_init  = 1'b1;
      m_cnt   = 0;
      m_rr    = 1'b0;
      m_count = '0;
    end else if (m_init) begin
      chk("ready_init", req_ready, 2'b00);
      e.a    = AW'(m_cnt);
      e.d    = terrain(m_cnt);
      e.c    = m_count;
      e.done = (m_cnt == DEPTH - 1);
      q.push_back(e);
      if (m_cnt == DEPTH - 1) begin
        m_init = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      el = req_valid & {2{blank}};
      if (el == 2'b11) g = m_rr ? 2'b10 : 2'b01;
      else g = el;
      chk("ready", req_ready, g);
      if (g != 2'b00) begin
        m_count++;
        e.a    = g[1] ? req_addr1 : req_addr0;
        e.d    = g[1] ? req_data1 : req_data0;
        e.c    = m_count;
        e.done = 1'b1;
        q.push_back(e);
        m_rr = g[0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [1:0] g;
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) cycle(g);
  endtask

  task automatic run_init();
    logic [1:0] g;
    req_valid = 2'b00;
    for (int i = 0; i < DEPTH + 4 && m_init; i++)
      cycle(g);
    chk("sweep_finished", m_init, 1'b0);
  endtask

  task automatic pulse_rst();
    logic [1:0] g;
    rst = 1'b1;
    cycle(g);
    rst = 1'b0;
  endtask

  task automatic traffic(input int n, input int pct,
                         input int pblank);
    logic [1:0] g;
    for (int i = 0; i < n; i++) begin
      blank = ($urandom_range(0, 99) < pblank);
      if (!req_valid[0] && $urandom_range(0, 99) < pct) begin
        req_valid[0] = 1'b1;
        req_addr0    = AW'($urandom);
        req_data0    = 5'($urandom);
      end
      if (!req_valid[1] && $urandom_range(0, 99) < pct) begin
        req_valid[1] = 1'b1;
        req_addr1    = AW'($urandom);
        req_data1    = 5'($urandom);
      end
      cycle(g);
      if (g[0]) req_valid[0] = 1'b0;
      if (g[1]) req_valid[1] = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    logic [1:0] g;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycle(g);
    chk("reset_state",
        {write_en, write_addr, write_data,
         init_done, edit_count}, 0);
    rst = 1'b0;

    run_init();
    idle(2);

    blank     = 1'b1;
    req_valid = 2'b01;
    req_addr0 = AW'(12'h234);
    req_data0 = 5'd3;
    cycle(g);
    req_valid = 2'b00;
    idle(1);

    req_valid = 2'b11;
    req_addr0 = AW'(12'h111);
    req_addr1 = AW'(12'h222);
    req_data0 = 5'd4;
    req_data1 = 5'd5;
    for (int i = 0; i < 4; i++) cycle(g);
    req_valid = 2'b00;
    idle(1);

    blank     = 1'b0;
    req_valid = 2'b10;
    req_addr1 = AW'(12'h3c5);
    req_data1 = 5'd7;
    for (int i = 0; i < 10; i++) cycle(g);
    blank = 1'b1;
    cycle(g);
    req_valid = 2'b00;
    idle(2);

    traffic(400, 40, 70);
    idle(2);

    pulse_rst();
    for (int i = 0; i < DEPTH / 2; i++) cycle(g);
    pulse_rst();
    run_init();
    idle(1);

    traffic(20, 60, 100);
    blank     = 1'b1;
    req_valid = 2'b01;
    req_addr0 = AW'(12'h055);
    req_data0 = 5'd9;
    rst       = 1'b1;
    cycle(g);
    rst       = 1'b0;
    req_valid = 2'b00;
    run_init();
    idle(1);

    traffic(65536, 100, 100);
    idle(3);
    chk("edit_count_wrap", edit_count, m_count);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
